// File: rtl/ab_pkg.sv
// Shared encodings for the ab address-generator sequencer: ab_op fields and
// constants, addressing-mode codes, index-mux codes and sequencer states.
package ab_pkg;

  // ab_op field positions
  localparam int ABH_MSB  = 9;
  localparam int ABH_LSB  = 8;
  localparam int HOLD_BIT = 7;
  localparam int PC_MSB   = 6;
  localparam int PC_LSB   = 5;
  localparam int BASE_MSB = 4;
  localparam int BASE_LSB = 3;
  localparam int OFS_MSB  = 2;
  localparam int OFS_LSB  = 1;
  localparam int CI_BIT   = 0;

  // Bits that update PC or the hold register; cleared while memory stalls.
  localparam logic [9:0] STALL_MASK = 10'h0E0;

  localparam logic [9:0] OP_INC_PC      = 10'h028;
  localparam logic [9:0] OP_PC_NOINC    = 10'h008;
  localparam logic [9:0] OP_ZPG         = 10'h006;
  localparam logic [9:0] OP_ZPG_HOLD    = 10'h086;
  localparam logic [9:0] OP_HOLD_INC_PG = 10'h019;
  localparam logic [9:0] OP_ABS_IDX     = 10'h212;
  localparam logic [9:0] OP_ABS_HOLD    = 10'h290;
  localparam logic [9:0] OP_HOLD_INC    = 10'h219;
  localparam logic [9:0] OP_JUMP        = 10'h030;

  typedef enum logic [3:0] {
    M_IMP  = 4'd0,
    M_IMM  = 4'd1,
    M_ZP   = 4'd2,
    M_ZPX  = 4'd3,
    M_ZPY  = 4'd4,
    M_ABS  = 4'd5,
    M_ABSX = 4'd6,
    M_ABSY = 4'd7,
    M_INDX = 4'd8,
    M_INDY = 4'd9,
    M_JMP  = 4'd10,
    M_JMPI = 4'd11
  } mode_e;

  typedef enum logic [1:0] {
    XY_ZERO = 2'd0,
    XY_X    = 2'd1,
    XY_Y    = 2'd2
  } xy_e;

  typedef enum logic [3:0] {
    S_RST0   = 4'd0,
    S_RST1   = 4'd1,
    S_JGO    = 4'd2,
    S_FETCH  = 4'd3,
    S_DECODE = 4'd4,
    S_ZDATA  = 4'd5,
    S_AHI    = 4'd6,
    S_ADATA  = 4'd7,
    S_IPTR   = 4'd8,
    S_IPHI   = 4'd9,
    S_IDATA  = 4'd10,
    S_JLO    = 4'd11,
    S_JHI    = 4'd12
  } state_e;

  // Undefined mode codes 12-15 behave as implied.
  function automatic mode_e norm_mode(input logic [3:0] m);
    if (m > 4'd11) return M_IMP;
    return mode_e'(m);
  endfunction

endpackage

// File: rtl/ab_seq.sv
// Addressing-mode sequencer: walks reset-vector, opcode and operand address cycles,
// decoding ab_op/xy_sel/strobes from state, latched mode and RDY (live mode only in DECODE).
module ab_seq
  import ab_pkg::*;
(
  input  logic       clk,
  input  logic       RST,
  input  logic       RDY,
  input  logic [3:0] mode,
  output logic [9:0] ab_op,
  output logic [1:0] xy_sel,
  output logic       dr_load,
  output logic       sync,
  output logic       done
);

  state_e     state_q, state_d;
  mode_e      mode_q, mode_d;
  mode_e      mode_dec;
  logic [9:0] op_raw;
  xy_e        xy_raw;
  logic       dr_raw;
  logic       done_raw;
  logic       sync_raw;

  assign mode_dec = norm_mode(mode);
  assign mode_d   = (state_q == S_DECODE) ? mode_dec : mode_q;

  always_ff @(posedge clk) begin
    if (RST) begin
      state_q <= S_RST0;
      mode_q  <= M_IMP;
    end else if (RDY) begin
      state_q <= state_d;
      mode_q  <= mode_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_raw   = OP_INC_PC;
    xy_raw   = XY_ZERO;
    dr_raw   = 1'b0;
    done_raw = 1'b0;
    sync_raw = 1'b0;
    case (state_q)
      S_RST0: state_d = S_RST1;
      S_RST1: begin
        dr_raw  = 1'b1;
        state_d = S_JGO;
      end
      S_JGO: begin
        op_raw   = OP_JUMP;
        sync_raw = 1'b1;
        state_d  = S_DECODE;
      end
      S_FETCH: begin
        sync_raw = 1'b1;
        state_d  = S_DECODE;
      end
      S_DECODE: begin
        case (mode_dec)
          M_IMM: begin
            done_raw = 1'b1;
            state_d  = S_FETCH;
          end
          M_ZP, M_ZPX, M_ZPY:                       state_d = S_ZDATA;
          M_ABS, M_ABSX, M_ABSY, M_JMP, M_JMPI:     state_d = S_AHI;
          M_INDX, M_INDY:                           state_d = S_IPTR;
          default: begin
            op_raw   = OP_PC_NOINC;
            done_raw = 1'b1;
            state_d  = S_FETCH;
          end
        endcase
      end
      S_ZDATA: begin
        op_raw   = OP_ZPG;
        xy_raw   = (mode_q == M_ZPX) ? XY_X : (mode_q == M_ZPY) ? XY_Y : XY_ZERO;
        done_raw = 1'b1;
        state_d  = S_FETCH;
      end
      S_AHI: begin
        dr_raw = 1'b1;
        case (mode_q)
          M_JMP: begin
            done_raw = 1'b1;
            state_d  = S_JGO;
          end
          M_JMPI:  state_d = S_JLO;
          default: state_d = S_ADATA;
        endcase
      end
      S_ADATA: begin
        op_raw   = OP_ABS_IDX;
        xy_raw   = (mode_q == M_ABSX) ? XY_X : (mode_q == M_ABSY) ? XY_Y : XY_ZERO;
        done_raw = 1'b1;
        state_d  = S_FETCH;
      end
      S_IPTR: begin
        op_raw  = OP_ZPG_HOLD;
        xy_raw  = (mode_q == M_INDX) ? XY_X : XY_ZERO;
        state_d = S_IPHI;
      end
      S_IPHI: begin
        // Pointer high byte stays in page 00 even when the low byte is FF.
        op_raw  = OP_HOLD_INC_PG;
        dr_raw  = 1'b1;
        state_d = S_IDATA;
      end
      S_IDATA: begin
        op_raw   = OP_ABS_IDX;
        xy_raw   = (mode_q == M_INDY) ? XY_Y : XY_ZERO;
        done_raw = 1'b1;
        state_d  = S_FETCH;
      end
      S_JLO: begin
        op_raw  = OP_ABS_HOLD;
        state_d = S_JHI;
      end
      S_JHI: begin
        // Full carry into ABH: the 65C02 fix for JMP (xxFF).
        op_raw   = OP_HOLD_INC;
        dr_raw   = 1'b1;
        done_raw = 1'b1;
        state_d  = S_JGO;
      end
      default: state_d = S_RST0;
    endcase
  end

  assign ab_op   = RDY ? op_raw : (op_raw & ~STALL_MASK);
  assign xy_sel  = xy_raw;
  assign dr_load = RDY & dr_raw;
  assign done    = RDY & done_raw;
  assign sync    = sync_raw;

endmodule

// File: tb/tb_ab_seq.sv
// Cycle-by-cycle check of the sequencer control word against a scoreboard of expected outputs.
module tb_ab_seq;

  logic       clk = 1'b0;
  logic       RST;
  logic       RDY;
  logic [3:0] mode;
  logic [9:0] ab_op;
  logic [1:0] xy_sel;
  logic       dr_load;
  logic       sync;
  logic       done;

  always #5 clk = ~clk;

  ab_seq dut (
    .clk     (clk),
    .RST     (RST),
    .RDY     (RDY),
    .mode    (mode),
    .ab_op   (ab_op),
    .xy_sel  (xy_sel),
    .dr_load (dr_load),
    .sync    (sync),
    .done    (done)
  );

  typedef struct {
    string       tag;
    logic [14:0] v;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check_eq(input string tag, input logic [14:0] obs, input logic [14:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got op=%h xy=%0d dr=%b sync=%b done=%b, want op=%h xy=%0d dr=%b sync=%b done=%b",
               tag, obs[14:5], obs[4:3], obs[2], obs[1], obs[0],
               exp[14:5], exp[4:3], exp[2], exp[1], exp[0]);
    end
  endtask

  function automatic logic [3:0] junk();
    return 4'($urandom_range(0, 15));
  endfunction

  task automatic step(input string tag, input logic rst, input logic rdy, input logic [3:0] m,
                      input logic [9:0] op, input logic [1:0] xy,
                      input logic dr, input logic sy, input logic dn);
    exp_t e;
    @(posedge clk);
    #1;
    RST  = rst;
    RDY  = rdy;
    mode = m;
    e.tag = tag;
    e.v   = {op, xy, dr, sy, dn};
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    check_eq(e.tag, {ab_op, xy_sel, dr_load, sync, done}, e.v);
  endtask

  // Non-decode cycle: live mode is noise and must not matter.
  task automatic run(input string tag, input logic [9:0] op, input logic [1:0] xy,
                     input logic dr, input logic sy, input logic dn);
    step(tag, 1'b0, 1'b1, junk(), op, xy, dr, sy, dn);
  endtask

  task automatic dec(input string tag, input logic [3:0] m, input logic [9:0] op, input logic dn);
    step(tag, 1'b0, 1'b1, m, op, 2'd0, 1'b0, 1'b0, dn);
  endtask

  task automatic fetch(input string tag);
    run(tag, 10'h028, 2'd0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    RST  = 1'b1;
    RDY  = 1'b1;
    mode = 4'd0;

    // Reset vector fetch
    step("rst0", 1'b0, 1'b1, junk(), 10'h028, 2'd0, 1'b0, 1'b0, 1'b0);
    run("rst1", 10'h028, 2'd0, 1'b1, 1'b0, 1'b0);
    run("jgo",  10'h030, 2'd0, 1'b0, 1'b1, 1'b0);

    // LDA abs,X
    dec("absx_dec", 4'd6, 10'h028, 1'b0);
    run("absx_ahi",   10'h028, 2'd0, 1'b1, 1'b0, 1'b0);
    run("absx_adata", 10'h212, 2'd1, 1'b0, 1'b0, 1'b1);
    fetch("absx_fetch");

    // LDA (zp),Y
    dec("indy_dec", 4'd9, 10'h028, 1'b0);
    run("indy_iptr",  10'h086, 2'd0, 1'b0, 1'b0, 1'b0);
    run("indy_iphi",  10'h019, 2'd0, 1'b1, 1'b0, 1'b0);
    run("indy_idata", 10'h212, 2'd2, 1'b0, 1'b0, 1'b1);
    fetch("indy_fetch");

    // JMP (abs)
    dec("jmpi_dec", 4'd11, 10'h028, 1'b0);
    run("jmpi_ahi", 10'h028, 2'd0, 1'b1, 1'b0, 1'b0);
    run("jmpi_jlo", 10'h290, 2'd0, 1'b0, 1'b0, 1'b0);
    run("jmpi_jhi", 10'h219, 2'd0, 1'b1, 1'b0, 1'b1);
    run("jmpi_jgo", 10'h030, 2'd0, 1'b0, 1'b1, 1'b0);

    // Short modes, including an undefined code acting as implied
    dec("imp_dec", 4'd0, 10'h008, 1'b1);
    fetch("imp_fetch");
    dec("imm_dec", 4'd1, 10'h028, 1'b1);
    fetch("imm_fetch");
    dec("m13_dec", 4'd13, 10'h008, 1'b1);
    fetch("m13_fetch");
    dec("zp_dec", 4'd2, 10'h028, 1'b0);
    run("zp_zdata", 10'h006, 2'd0, 1'b0, 1'b0, 1'b1);
    fetch("zp_fetch");
    dec("zpx_dec", 4'd3, 10'h028, 1'b0);
    run("zpx_zdata", 10'h006, 2'd1, 1'b0, 1'b0, 1'b1);
    fetch("zpx_fetch");
    dec("zpy_dec", 4'd4, 10'h028, 1'b0);
    run("zpy_zdata", 10'h006, 2'd2, 1'b0, 1'b0, 1'b1);
    fetch("zpy_fetch");
    dec("absy_dec", 4'd7, 10'h028, 1'b0);
    run("absy_ahi",   10'h028, 2'd0, 1'b1, 1'b0, 1'b0);
    run("absy_adata", 10'h212, 2'd2, 1'b0, 1'b0, 1'b1);
    fetch("absy_fetch");
    dec("jmp_dec", 4'd10, 10'h028, 1'b0);
    run("jmp_ahi", 10'h028, 2'd0, 1'b1, 1'b0, 1'b1);
    run("jmp_jgo", 10'h030, 2'd0, 1'b0, 1'b1, 1'b0);

    // Stalls: in DECODE, in AHI (3 cycles), in ADATA and in FETCH
    step("abs_dec_stall", 1'b0, 1'b0, 4'd5, 10'h008, 2'd0, 1'b0, 1'b0, 1'b0);
    dec("abs_dec", 4'd5, 10'h028, 1'b0);
    for (int i = 0; i < 3; i++)
      step("abs_ahi_stall", 1'b0, 1'b0, junk(), 10'h008, 2'd0, 1'b0, 1'b0, 1'b0);
    run("abs_ahi", 10'h028, 2'd0, 1'b1, 1'b0, 1'b0);
    step("abs_adata_stall", 1'b0, 1'b0, junk(), 10'h212, 2'd0, 1'b0, 1'b0, 1'b0);
    run("abs_adata", 10'h212, 2'd0, 1'b0, 1'b0, 1'b1);
    step("fetch_stall", 1'b0, 1'b0, junk(), 10'h008, 2'd0, 1'b0, 1'b1, 1'b0);
    fetch("abs_fetch");
    step("imp_dec_stall", 1'b0, 1'b0, 4'd0, 10'h008, 2'd0, 1'b0, 1'b0, 1'b0);
    dec("imp2_dec", 4'd0, 10'h008, 1'b1);
    fetch("imp2_fetch");

    // Reset in IPHI while stalled: reset must win over RDY
    dec("indx_dec", 4'd8, 10'h028, 1'b0);
    run("indx_iptr", 10'h086, 2'd1, 1'b0, 1'b0, 1'b0);
    step("indx_iphi_rst", 1'b1, 1'b0, junk(), 10'h019, 2'd0, 1'b0, 1'b0, 1'b0);
    run("rst0_again", 10'h028, 2'd0, 1'b0, 1'b0, 1'b0);
    run("rst1_again", 10'h028, 2'd0, 1'b1, 1'b0, 1'b0);
    run("jgo_again",  10'h030, 2'd0, 1'b0, 1'b1, 1'b0);

    // INDX full path after reset
    dec("indx2_dec", 4'd8, 10'h028, 1'b0);
    run("indx2_iptr",  10'h086, 2'd1, 1'b0, 1'b0, 1'b0);
    run("indx2_iphi",  10'h019, 2'd0, 1'b1, 1'b0, 1'b0);
    run("indx2_idata", 10'h212, 2'd0, 1'b0, 1'b0, 1'b1);
    fetch("indx2_fetch");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
